// File: rtl/seq_tx.sv
// Serial pattern transmitter: loads a pattern word via valid/ready and shifts it
// out MSB-first on a registered bit, optionally repeated, with a done pulse at the end.
module seq_tx #(
   parameter int   WIDTH    = 8,
   parameter int   REP_W    = 4,
   parameter logic IDLE_BIT = 1'b0,
   localparam int  LW       = $clog2(WIDTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic [LW-1:0]    len_in,
   input  logic [REP_W-1:0] rep_in,
   input  logic             valid_in,
   output logic             ready_out,
   input  logic             abort,
   output logic             Out,
   output logic             busy,
   output logic             done
);

   localparam int IW = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [LW-1:0] WIDTH_L = LW'(WIDTH);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [IW-1:0]    lenm1_q, lenm1_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [REP_W-1:0] rep_q, rep_d;
   logic             out_q, out_d;

   logic [LW-1:0]    len_eff;
   logic [IW-1:0]    lenm1_in;
   logic [IW-1:0]    idx_dec;

   // Lengths of 0 or beyond WIDTH fall back to the full word.
   always_comb begin
      len_eff  = (len_in == '0 || len_in > WIDTH_L) ? WIDTH_L : len_in;
      lenm1_in = IW'(len_eff - LW'(1));
      idx_dec  = idx_q - IW'(1);
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      lenm1_d = lenm1_q;
      idx_d   = idx_q;
      rep_d   = rep_q;
      out_d   = out_q;
      case (state_q)
         S_IDLE: begin
            out_d = IDLE_BIT;
            if (valid_in) begin
               state_d = S_SHIFT;
               data_d  = data_in;
               lenm1_d = lenm1_in;
               idx_d   = lenm1_in;
               rep_d   = rep_in;
               out_d   = data_in[lenm1_in];
            end
         end
         S_SHIFT: begin
            if (abort) begin
               state_d = S_IDLE;
               rep_d   = '0;
               idx_d   = '0;
               out_d   = IDLE_BIT;
            end else if (idx_q != '0) begin
               idx_d = idx_dec;
               out_d = data_q[idx_dec];
            end else if (rep_q != '0) begin
               // Reload from the captured word with no gap cycle between repetitions.
               rep_d = rep_q - REP_W'(1);
               idx_d = lenm1_q;
               out_d = data_q[lenm1_q];
            end else begin
               state_d = S_DONE;
               out_d   = IDLE_BIT;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            out_d   = IDLE_BIT;
         end
         default: begin
            state_d = S_IDLE;
            out_d   = IDLE_BIT;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         lenm1_q <= '0;
         idx_q   <= '0;
         rep_q   <= '0;
         out_q   <= IDLE_BIT;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         lenm1_q <= lenm1_d;
         idx_q   <= idx_d;
         rep_q   <= rep_d;
         out_q   <= out_d;
      end
   end

   assign Out       = out_q;
   assign busy      = (state_q == S_SHIFT);
   assign done      = (state_q == S_DONE);
   assign ready_out = (state_q == S_IDLE);

endmodule
